// File: rtl/minute_hour_counter_pkg.sv
// Shared constants and types for the seconds / minute-hour / calendar time-of-day datapath.
package minute_hour_counter_pkg;
  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;
  localparam int DATA_W   = 6;

  typedef enum logic {
    SEL_MIN  = 1'b0,
    SEL_HOUR = 1'b1
  } load_sel_e;
endpackage

// File: rtl/minute_hour_counter_bcd_split.sv
// Combinational split of a 0-59 binary value into BCD tens and units digits.
module bcd_split (
  input  logic [5:0] bin,
  output logic [2:0] tens,
  output logic [3:0] units
);
  always_comb begin
    tens  = 3'd0;
    units = bin[3:0];
    if (bin >= 6'd50) begin
      tens  = 3'd5;
      units = 4'(bin - 6'd50);
    end else if (bin >= 6'd40) begin
      tens  = 3'd4;
      units = 4'(bin - 6'd40);
    end else if (bin >= 6'd30) begin
      tens  = 3'd3;
      units = 4'(bin - 6'd30);
    end else if (bin >= 6'd20) begin
      tens  = 3'd2;
      units = 4'(bin - 6'd20);
    end else if (bin >= 6'd10) begin
      tens  = 3'd1;
      units = 4'(bin - 6'd10);
    end
  end
endmodule

// File: rtl/minute_hour_counter.sv
// Minutes/hours stage: counts seconds-wrap pulses, supports field loads, and
// drives binary, BCD and 12/24h display values plus the midnight day_tick.
module minute_hour_counter
  import minute_hour_counter_pkg::*;
#(
  parameter int MIN_MAX  = minute_hour_counter_pkg::MIN_MAX,
  parameter int HOUR_MAX = minute_hour_counter_pkg::HOUR_MAX,
  parameter int DATA_W   = minute_hour_counter_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              enable,
  input  logic              sec_carry,
  input  logic              load,
  input  logic              load_sel,
  input  logic [DATA_W-1:0] databus,
  input  logic              mode12,
  output logic [5:0]        min,
  output logic [4:0]        hour,
  output logic [2:0]        min_tens,
  output logic [3:0]        min_units,
  output logic [1:0]        hour_tens,
  output logic [3:0]        hour_units,
  output logic              pm,
  output logic              day_tick,
  output logic              load_err
);
  logic [5:0] disp_hour;
  logic [2:0] hour_tens_w;
  logic       unused_hour_tens_msb;

  // Full-width compares reject any set bit above the field width.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      min      <= '0;
      hour     <= '0;
      day_tick <= 1'b0;
      load_err <= 1'b0;
    end else begin
      day_tick <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (load_sel_e'(load_sel) == SEL_HOUR) begin
          if (databus <= DATA_W'(HOUR_MAX)) hour <= databus[4:0];
          else                              load_err <= 1'b1;
        end else begin
          if (databus <= DATA_W'(MIN_MAX)) min <= databus[5:0];
          else                             load_err <= 1'b1;
        end
      end else if (enable && sec_carry) begin
        if (min < 6'(MIN_MAX)) begin
          min <= min + 6'd1;
        end else begin
          min <= '0;
          if (hour < 5'(HOUR_MAX)) begin
            hour <= hour + 5'd1;
          end else begin
            hour     <= '0;
            day_tick <= 1'b1;
          end
        end
      end
    end
  end

  // 12h display shows midnight and noon as 12; the stored hour stays 0-23.
  always_comb begin
    disp_hour = {1'b0, hour};
    if (mode12) begin
      if (hour == 5'd0)       disp_hour = 6'd12;
      else if (hour > 5'd12)  disp_hour = {1'b0, hour - 5'd12};
    end
  end

  assign pm = (hour >= 5'd12);

  bcd_split u_min_bcd (
    .bin   (min),
    .tens  (min_tens),
    .units (min_units)
  );

  bcd_split u_hour_bcd (
    .bin   (disp_hour),
    .tens  (hour_tens_w),
    .units (hour_units)
  );

  assign hour_tens            = hour_tens_w[1:0];
  assign unused_hour_tens_msb = hour_tens_w[2];
endmodule

// File: tb/tb_minute_hour_counter.sv
// Self-checking bench: directed plan steps then random traffic, checked against a
// minutes-of-day reference model.
module tb_minute_hour_counter;
  logic       clk = 1'b0;
  logic       clear_n;
  logic       enable, sec_carry, load, load_sel, mode12;
  logic [5:0] databus;
  logic [5:0] min;
  logic [4:0] hour;
  logic [2:0] min_tens;
  logic [3:0] min_units;
  logic [1:0] hour_tens;
  logic [3:0] hour_units;
  logic       pm, day_tick, load_err;

  int nvec = 0;
  int nerr = 0;

  // Reference model: time as minutes since midnight.
  int t      = 0;
  bit tick_e = 0;
  bit err_e  = 0;

  always #5 clk = ~clk;

  minute_hour_counter dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .enable     (enable),
    .sec_carry  (sec_carry),
    .load       (load),
    .load_sel   (load_sel),
    .databus    (databus),
    .mode12     (mode12),
    .min        (min),
    .hour       (hour),
    .min_tens   (min_tens),
    .min_units  (min_units),
    .hour_tens  (hour_tens),
    .hour_units (hour_units),
    .pm         (pm),
    .day_tick   (day_tick),
    .load_err   (load_err)
  );

  task automatic chk(input string step, input string f, input logic [31:0] obs, input int exp);
    nvec++;
    assert (obs === 32'(exp)) else begin
      nerr++;
      $error("FAIL %s.%s observed=%0d expected=%0d", step, f, obs, exp);
    end
  endtask

  task automatic check_all(input string step);
    int h, m, dh;
    h  = t / 60;
    m  = t % 60;
    dh = mode12 ? ((h % 12 == 0) ? 12 : h % 12) : h;
    chk(step, "min",        32'(min),        m);
    chk(step, "hour",       32'(hour),       h);
    chk(step, "min_tens",   32'(min_tens),   m / 10);
    chk(step, "min_units",  32'(min_units),  m % 10);
    chk(step, "hour_tens",  32'(hour_tens),  dh / 10);
    chk(step, "hour_units", 32'(hour_units), dh % 10);
    chk(step, "pm",         32'(pm),         (h >= 12) ? 1 : 0);
    chk(step, "day_tick",   32'(day_tick),   int'(tick_e));
    chk(step, "load_err",   32'(load_err),   int'(err_e));
  endtask

  task automatic model_edge();
    int v;
    v      = int'(databus);
    tick_e = 0;
    err_e  = 0;
    if (load) begin
      if (load_sel) begin
        if (v <= 23) t = v * 60 + t % 60;
        else         err_e = 1;
      end else begin
        if (v <= 59) t = (t / 60) * 60 + v;
        else         err_e = 1;
      end
    end else if (enable && sec_carry) begin
      t = t + 1;
      if (t == 24 * 60) begin
        t      = 0;
        tick_e = 1;
      end
    end
  endtask

  task automatic cyc(input string step);
    @(posedge clk);
    model_edge();
    #1;
    check_all(step);
  endtask

  task automatic do_load(input string step, input logic sel, input logic [5:0] val);
    load     = 1'b1;
    load_sel = sel;
    databus  = val;
    cyc(step);
    load     = 1'b0;
  endtask

  task automatic carries(input string step, input int n);
    sec_carry = 1'b1;
    repeat (n) cyc(step);
    sec_carry = 1'b0;
  endtask

  initial begin
    clear_n = 1'b0; enable = 1'b1; sec_carry = 1'b0; load = 1'b0;
    load_sel = 1'b0; databus = '0; mode12 = 1'b0;
    #2 check_all("reset");
    mode12 = 1'b1;
    #1 check_all("reset12");
    mode12 = 1'b0;
    // A carry held during reset must not count on the edge where clear_n is low.
    sec_carry = 1'b1;
    @(posedge clk);
    #1 check_all("reset_edge");
    sec_carry = 1'b0;
    #4 clear_n = 1'b1;

    // Asynchronous reset mid-count.
    do_load("ld_h5", 1'b1, 6'd5);
    do_load("ld_m30", 1'b0, 6'd30);
    mode12 = 1'b1;
    #2 clear_n = 1'b0;
    t = 0; tick_e = 0; err_e = 0;
    #1 check_all("async_rst");
    #2 clear_n = 1'b1;
    mode12 = 1'b0;

    // Minute wrap 10:59 -> 11:00.
    do_load("ld_h10", 1'b1, 6'd10);
    do_load("ld_m59", 1'b0, 6'd59);
    carries("min_wrap", 1);
    cyc("idle");

    // Midnight rollover then back-to-back carries.
    do_load("ld_h23", 1'b1, 6'd23);
    do_load("ld_m59b", 1'b0, 6'd59);
    carries("midnight", 1);
    carries("b2b", 3);

    // Load rules.
    do_load("ld_h24_err", 1'b1, 6'd24);
    cyc("err_clear");
    do_load("ld_h17", 1'b1, 6'd17);
    mode12 = 1'b1;
    #1 check_all("disp12_17");
    do_load("ld_m60_err", 1'b0, 6'd60);
    load = 1'b1; load_sel = 1'b0; databus = 6'd63;
    cyc("hold_err1");
    cyc("hold_err2");
    load = 1'b0;
    mode12 = 1'b0;

    // Load beats a simultaneous carry at 23:59.
    do_load("ld_h23c", 1'b1, 6'd23);
    do_load("ld_m59c", 1'b0, 6'd59);
    sec_carry = 1'b1;
    do_load("ld_vs_carry", 1'b0, 6'd10);
    sec_carry = 1'b0;
    cyc("no_tick");

    // Disabled carries are dropped.
    enable = 1'b0;
    carries("disabled", 5);
    enable = 1'b1;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      enable    = ($urandom_range(0, 3) != 0);
      sec_carry = $urandom_range(0, 1);
      load      = ($urandom_range(0, 9) == 0);
      load_sel  = $urandom_range(0, 1);
      databus   = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                              : 6'($urandom_range(0, 59));
      mode12    = $urandom_range(0, 1);
      cyc("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
